// File: rtl/reservation_station_pkg.sv
// Shared configuration and opcode ids for the ALU reservation station.
// The station never decodes opcodes; they are carried through to the ALU untouched.
package reservation_station_pkg;

  localparam int unsigned RS_SIZE_DEF   = 16;
  localparam int unsigned ROB_IDX_W_DEF = 4;
  localparam int unsigned OPCODE_W      = 6;
  localparam int unsigned DATA_W        = 32;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_ADDI  = 6'd19,
    OP_ADD   = 6'd28,
    OP_SUB   = 6'd29,
    OP_AND   = 6'd37
  } alu_op_e;

endpackage

// File: rtl/reservation_station_priority_enc.sv
// Lowest-set-bit encoder: reports whether any request bit is set and the index
// of the lowest one.
module rs_priority_enc #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo ALU reservation station: buffers issued ops, snoops the ALU/LSB CDBs
// for operand wakeup and dispatches the lowest-index ready op per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE   = RS_SIZE_DEF,
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 issue_valid,
  input  logic [5:0]           issue_opcode,
  input  logic [31:0]          issue_vj,
  input  logic [31:0]          issue_vk,
  input  logic [ROB_IDX_W-1:0] issue_qj,
  input  logic [ROB_IDX_W-1:0] issue_qk,
  input  logic                 issue_qj_valid,
  input  logic                 issue_qk_valid,
  input  logic [31:0]          issue_A,
  input  logic [ROB_IDX_W-1:0] issue_rob_pos,
  output logic                 rs_full,
  input  logic                 alu_cdb_valid,
  input  logic [ROB_IDX_W-1:0] alu_cdb_rob_pos,
  input  logic [31:0]          alu_cdb_val,
  input  logic                 lsb_cdb_valid,
  input  logic [ROB_IDX_W-1:0] lsb_cdb_rob_pos,
  input  logic [31:0]          lsb_cdb_val,
  output logic                 exe_valid,
  output logic [5:0]           exe_opcode,
  output logic [31:0]          exe_vj,
  output logic [31:0]          exe_vk,
  output logic [31:0]          exe_A,
  output logic [ROB_IDX_W-1:0] exe_rob_pos
);

  localparam int unsigned RS_IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy_q, busy_d;
  logic [RS_SIZE-1:0]   qj_valid_q, qj_valid_d;
  logic [RS_SIZE-1:0]   qk_valid_q, qk_valid_d;
  logic [5:0]           opcode_q [RS_SIZE];
  logic [5:0]           opcode_d [RS_SIZE];
  logic [31:0]          vj_q     [RS_SIZE];
  logic [31:0]          vj_d     [RS_SIZE];
  logic [31:0]          vk_q     [RS_SIZE];
  logic [31:0]          vk_d     [RS_SIZE];
  logic [31:0]          a_q      [RS_SIZE];
  logic [31:0]          a_d      [RS_SIZE];
  logic [ROB_IDX_W-1:0] qj_q     [RS_SIZE];
  logic [ROB_IDX_W-1:0] qj_d     [RS_SIZE];
  logic [ROB_IDX_W-1:0] qk_q     [RS_SIZE];
  logic [ROB_IDX_W-1:0] qk_d     [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_q    [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_d    [RS_SIZE];

  logic                 exe_valid_q, exe_valid_d;
  logic [5:0]           exe_opcode_q, exe_opcode_d;
  logic [31:0]          exe_vj_q, exe_vj_d;
  logic [31:0]          exe_vk_q, exe_vk_d;
  logic [31:0]          exe_a_q, exe_a_d;
  logic [ROB_IDX_W-1:0] exe_rob_q, exe_rob_d;

  logic [RS_SIZE-1:0]   ready_req;
  logic                 free_found, ready_found;
  logic [RS_IDX_W-1:0]  free_idx, ready_idx;

  assign ready_req = busy_q & ~qj_valid_q & ~qk_valid_q;
  assign rs_full   = &busy_q;

  rs_priority_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
    .req   (~busy_q),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_priority_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_enc (
    .req   (ready_req),
    .found (ready_found),
    .idx   (ready_idx)
  );

  always_comb begin
    busy_d       = busy_q;
    qj_valid_d   = qj_valid_q;
    qk_valid_d   = qk_valid_q;
    opcode_d     = opcode_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    a_d          = a_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    rob_d        = rob_q;
    exe_valid_d  = 1'b0;
    exe_opcode_d = exe_opcode_q;
    exe_vj_d     = exe_vj_q;
    exe_vk_d     = exe_vk_q;
    exe_a_d      = exe_a_q;
    exe_rob_d    = exe_rob_q;

    if (clear) begin
      busy_d = '0;
    end else begin
      // Wakeup: ALU bus is checked first so it wins on an (illegal) double match.
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && qj_valid_q[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_pos == qj_q[i]) begin
            vj_d[i]       = alu_cdb_val;
            qj_valid_d[i] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_pos == qj_q[i]) begin
            vj_d[i]       = lsb_cdb_val;
            qj_valid_d[i] = 1'b0;
          end
        end
        if (busy_q[i] && qk_valid_q[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_pos == qk_q[i]) begin
            vk_d[i]       = alu_cdb_val;
            qk_valid_d[i] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_pos == qk_q[i]) begin
            vk_d[i]       = lsb_cdb_val;
            qk_valid_d[i] = 1'b0;
          end
        end
      end

      if (ready_found) begin
        exe_valid_d         = 1'b1;
        exe_opcode_d        = opcode_q[ready_idx];
        exe_vj_d            = vj_q[ready_idx];
        exe_vk_d            = vk_q[ready_idx];
        exe_a_d             = a_q[ready_idx];
        exe_rob_d           = rob_q[ready_idx];
        busy_d[ready_idx]   = 1'b0;
      end

      // The free slot comes from current busy bits, so it never collides with the dispatched one.
      if (issue_valid && free_found) begin
        busy_d[free_idx]   = 1'b1;
        opcode_d[free_idx] = issue_opcode;
        a_d[free_idx]      = issue_A;
        rob_d[free_idx]    = issue_rob_pos;
        qj_d[free_idx]     = issue_qj;
        qk_d[free_idx]     = issue_qk;
        vj_d[free_idx]     = issue_vj;
        vk_d[free_idx]     = issue_vk;
        qj_valid_d[free_idx] = issue_qj_valid;
        qk_valid_d[free_idx] = issue_qk_valid;
        if (issue_qj_valid) begin
          if (alu_cdb_valid && alu_cdb_rob_pos == issue_qj) begin
            vj_d[free_idx]       = alu_cdb_val;
            qj_valid_d[free_idx] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_pos == issue_qj) begin
            vj_d[free_idx]       = lsb_cdb_val;
            qj_valid_d[free_idx] = 1'b0;
          end
        end
        if (issue_qk_valid) begin
          if (alu_cdb_valid && alu_cdb_rob_pos == issue_qk) begin
            vk_d[free_idx]       = alu_cdb_val;
            qk_valid_d[free_idx] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_pos == issue_qk) begin
            vk_d[free_idx]       = lsb_cdb_val;
            qk_valid_d[free_idx] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      qj_valid_q   <= '0;
      qk_valid_q   <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        opcode_q[i] <= '0;
        vj_q[i]     <= '0;
        vk_q[i]     <= '0;
        a_q[i]      <= '0;
        qj_q[i]     <= '0;
        qk_q[i]     <= '0;
        rob_q[i]    <= '0;
      end
      exe_valid_q  <= 1'b0;
      exe_opcode_q <= '0;
      exe_vj_q     <= '0;
      exe_vk_q     <= '0;
      exe_a_q      <= '0;
      exe_rob_q    <= '0;
    end else if (rdy) begin
      busy_q       <= busy_d;
      qj_valid_q   <= qj_valid_d;
      qk_valid_q   <= qk_valid_d;
      opcode_q     <= opcode_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      a_q          <= a_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      rob_q        <= rob_d;
      exe_valid_q  <= exe_valid_d;
      exe_opcode_q <= exe_opcode_d;
      exe_vj_q     <= exe_vj_d;
      exe_vk_q     <= exe_vk_d;
      exe_a_q      <= exe_a_d;
      exe_rob_q    <= exe_rob_d;
    end
  end

  assign exe_valid   = exe_valid_q;
  assign exe_opcode  = exe_opcode_q;
  assign exe_vj      = exe_vj_q;
  assign exe_vk      = exe_vk_q;
  assign exe_A       = exe_a_q;
  assign exe_rob_pos = exe_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus random
// traffic, all compared cycle by cycle against an entry-table model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        issue_valid;
  logic [5:0]  issue_opcode;
  logic [31:0] issue_vj, issue_vk, issue_A;
  logic [3:0]  issue_qj, issue_qk, issue_rob_pos;
  logic        issue_qj_valid, issue_qk_valid;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_pos, lsb_cdb_rob_pos;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        exe_valid;
  logic [5:0]  exe_opcode;
  logic [31:0] exe_vj, exe_vk, exe_A;
  logic [3:0]  exe_rob_pos;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE(16), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_A(issue_A), .issue_rob_pos(issue_rob_pos), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_pos(alu_cdb_rob_pos), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_pos(lsb_cdb_rob_pos), .lsb_cdb_val(lsb_cdb_val),
    .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_vj(exe_vj), .exe_vk(exe_vk),
    .exe_A(exe_A), .exe_rob_pos(exe_rob_pos)
  );

  typedef struct {
    bit        busy;
    bit [5:0]  op;
    bit [31:0] vj, vk, a;
    bit [3:0]  qj, qk, rob;
    bit        qjv, qkv;
  } ent_t;

  ent_t      m [16];
  bit        m_ev;
  bit [5:0]  m_eop;
  bit [31:0] m_evj, m_evk, m_ea;
  bit [3:0]  m_erob;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cdb_hit(input bit [3:0] tag, output bit [31:0] val);
    val = '0;
    if (alu_cdb_valid && alu_cdb_rob_pos == tag) begin val = alu_cdb_val; return 1'b1; end
    if (lsb_cdb_valid && lsb_cdb_rob_pos == tag) begin val = lsb_cdb_val; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
    m_ev = 0; m_eop = '0; m_evj = '0; m_evk = '0; m_ea = '0; m_erob = '0;
  endtask

  // Next-state of the model from the inputs currently on the pins.
  task automatic model_next();
    ent_t      old [16];
    int        disp = -1;
    int        slot = -1;
    bit [31:0] v;
    if (!rdy) return;
    if (clear) begin
      for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
      m_ev = 1'b0;
      return;
    end
    old = m;
    for (int i = 15; i >= 0; i--) begin
      if (old[i].busy && !old[i].qjv && !old[i].qkv) disp = i;
      if (!old[i].busy) slot = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (old[i].busy && old[i].qjv && cdb_hit(old[i].qj, v)) begin m[i].vj = v; m[i].qjv = 1'b0; end
      if (old[i].busy && old[i].qkv && cdb_hit(old[i].qk, v)) begin m[i].vk = v; m[i].qkv = 1'b0; end
    end
    m_ev = (disp >= 0);
    if (disp >= 0) begin
      m_eop = old[disp].op; m_evj = old[disp].vj; m_evk = old[disp].vk;
      m_ea  = old[disp].a;  m_erob = old[disp].rob;
      m[disp].busy = 1'b0;
    end
    if (issue_valid && slot >= 0) begin
      m[slot].busy = 1'b1; m[slot].op = issue_opcode; m[slot].a = issue_A;
      m[slot].rob = issue_rob_pos; m[slot].qj = issue_qj; m[slot].qk = issue_qk;
      m[slot].vj = issue_vj; m[slot].qjv = issue_qj_valid;
      m[slot].vk = issue_vk; m[slot].qkv = issue_qk_valid;
      if (issue_qj_valid && cdb_hit(issue_qj, v)) begin m[slot].vj = v; m[slot].qjv = 1'b0; end
      if (issue_qk_valid && cdb_hit(issue_qk, v)) begin m[slot].vk = v; m[slot].qkv = 1'b0; end
    end
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; issue_valid = 1'b0; issue_opcode = '0;
    issue_vj = '0; issue_vk = '0; issue_A = '0; issue_qj = '0; issue_qk = '0;
    issue_qj_valid = 1'b0; issue_qk_valid = 1'b0; issue_rob_pos = '0;
    alu_cdb_valid = 1'b0; alu_cdb_rob_pos = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_rob_pos = '0; lsb_cdb_val = '0;
  endtask

  task automatic set_issue(input bit [5:0] op, input bit [31:0] vj, input bit qjv, input bit [3:0] qj,
                           input bit [31:0] vk, input bit qkv, input bit [3:0] qk,
                           input bit [31:0] a, input bit [3:0] rob);
    issue_valid = 1'b1; issue_opcode = op; issue_vj = vj; issue_qj_valid = qjv; issue_qj = qj;
    issue_vk = vk; issue_qk_valid = qkv; issue_qk = qk; issue_A = a; issue_rob_pos = rob;
  endtask

  task automatic step();
    check("rs_full", 32'(rs_full), 32'(m_full()));
    model_next();
    @(posedge clk);
    #1;
    check("exe_valid",  32'(exe_valid),   32'(m_ev));
    check("exe_opcode", 32'(exe_opcode),  32'(m_eop));
    check("exe_vj",     exe_vj,           m_evj);
    check("exe_vk",     exe_vk,           m_evk);
    check("exe_A",      exe_A,            m_ea);
    check("exe_rob",    32'(exe_rob_pos), 32'(m_erob));
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_exe_valid", 32'(exe_valid), 32'd0);
    check("rst_rs_full", 32'(rs_full), 32'd0);
    rst = 1'b1;

    // Reset mid-operation: one op dispatched, three left pending.
    set_issue(OP_ADDI, 32'h1234, 0, 0, 32'h55, 0, 0, 32'h77, 4'd9); step();
    set_issue(OP_ADD, 0, 1, 4'd1, 0, 0, 0, 0, 4'd1); step();
    set_issue(OP_ADD, 0, 1, 4'd2, 0, 0, 0, 0, 4'd2); step();
    set_issue(OP_ADD, 0, 1, 4'd3, 0, 0, 0, 0, 4'd3); step();
    idle();
    check("pre_rst_exe_vj", exe_vj, 32'h1234);
    #2 rst = 1'b0;
    #1;
    check("arst_exe_valid", 32'(exe_valid), 32'd0);
    check("arst_exe_vj", exe_vj, 32'd0);
    check("arst_exe_A", exe_A, 32'd0);
    check("arst_exe_rob", 32'(exe_rob_pos), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd1;
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_pos = 4'd2; step();
    alu_cdb_rob_pos = 4'd3; lsb_cdb_valid = 1'b0; step();
    idle(); step();
    check("arst_no_leftover", 32'(exe_valid), 32'd0);

    // Ready ADD: exe two cycles after issue, then idle.
    set_issue(OP_ADD, 32'd5, 0, 0, 32'd7, 0, 0, 32'd0, 4'd3); step();
    check("add_t1_valid", 32'(exe_valid), 32'd0);
    idle(); step();
    check("add_valid", 32'(exe_valid), 32'd1);
    check("add_op", 32'(exe_opcode), 32'(OP_ADD));
    check("add_vj", exe_vj, 32'd5);
    check("add_vk", exe_vk, 32'd7);
    check("add_rob", 32'(exe_rob_pos), 32'd3);
    step();
    check("add_after", 32'(exe_valid), 32'd0);

    // LSB wakeup of a pending SUB.
    set_issue(OP_SUB, 0, 1, 4'd2, 32'd1, 0, 0, 0, 4'd4); step();
    idle(); step(); step();
    check("sub_wait", 32'(exe_valid), 32'd0);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_pos = 4'd2; lsb_cdb_val = 32'd10; step();
    check("sub_t3", 32'(exe_valid), 32'd0);
    idle(); step();
    check("sub_valid", 32'(exe_valid), 32'd1);
    check("sub_vj", exe_vj, 32'd10);
    check("sub_vk", exe_vk, 32'd1);
    check("sub_rob", 32'(exe_rob_pos), 32'd4);

    // Same-cycle forward from the ALU bus on issue.
    set_issue(OP_AND, 32'd3, 0, 0, 0, 1, 4'd6, 0, 4'd8);
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd6; alu_cdb_val = 32'hFFFF_FFFF; step();
    idle(); step();
    check("fwd_valid", 32'(exe_valid), 32'd1);
    check("fwd_vk", exe_vk, 32'hFFFF_FFFF);

    // Fill all entries, drop an extra issue, wake entry 9.
    for (int i = 0; i < 16; i++) begin
      set_issue(OP_ADD, 0, 1, 4'(i), 32'(i), 0, 0, 32'(100 + i), 4'(i)); step();
    end
    check("full_set", 32'(rs_full), 32'd1);
    set_issue(OP_BEQ, 32'hDEAD, 0, 0, 0, 1, 4'd9, 0, 4'd15); step();
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd9; alu_cdb_val = 32'h99; step();
    check("full_hold", 32'(rs_full), 32'd1);
    check("full_wake_nodisp", 32'(exe_valid), 32'd0);
    idle(); step();
    check("full_disp_rob", 32'(exe_rob_pos), 32'd9);
    check("full_disp_vj", exe_vj, 32'h99);
    check("full_drop", 32'(rs_full), 32'd0);

    // Flush with a simultaneous issue.
    set_issue(OP_ADD, 32'd1, 0, 0, 32'd2, 0, 0, 0, 4'd5);
    clear = 1'b1; step();
    check("clr_valid", 32'(exe_valid), 32'd0);
    check("clr_full", 32'(rs_full), 32'd0);
    idle(); step();
    check("clr_not_stored", 32'(exe_valid), 32'd0);

    // Ordering: wake entries 1 and 5 together, freeze between dispatches.
    for (int i = 0; i < 6; i++) begin
      set_issue(OP_ADD, 0, 1, 4'(10 + i), 32'(i), 0, 0, 0, 4'(i)); step();
    end
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd11; alu_cdb_val = 32'h11;
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_pos = 4'd15; lsb_cdb_val = 32'h15; step();
    idle(); step();
    check("ord_first", 32'(exe_rob_pos), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("ord_frz_valid", 32'(exe_valid), 32'd1);
      check("ord_frz_rob", 32'(exe_rob_pos), 32'd1);
    end
    rdy = 1'b1; step();
    check("ord_second", 32'(exe_rob_pos), 32'd5);
    check("ord_second_vj", exe_vj, 32'h15);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1)
        set_issue(6'($urandom_range(0, 40)), $urandom, 1'($urandom), 4'($urandom),
                  $urandom, 1'($urandom), 4'($urandom), $urandom, 4'($urandom));
      alu_cdb_valid = 1'($urandom); alu_cdb_rob_pos = 4'($urandom); alu_cdb_val = $urandom;
      lsb_cdb_valid = 1'($urandom); lsb_cdb_rob_pos = 4'($urandom); lsb_cdb_val = $urandom;
      if (alu_cdb_valid && lsb_cdb_valid && alu_cdb_rob_pos == lsb_cdb_rob_pos) lsb_cdb_valid = 1'b0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
